bcd_counter_n: RTL and testbench
================================

Name: bcd_counter_n

Overview:
Parametrised N-digit BCD up/down counter with programmable wrap range, enable, synchronous load and wrap/error flags. Successor to the fixed 2-digit 01..99 display counter. Feeds 7-segment decoder and scoreboard logic in the display datapath.

Parameters:
DIGITS, 2, number of BCD digits; count width = 4*DIGITS.
MIN_BCD, 'h01, lowest count value, BCD-encoded, 4*DIGITS bits; also the reset value.
MAX_BCD, 'h99, highest count value, BCD-encoded; MIN_BCD < MAX_BCD; every nibble of both must be ≤ 9.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-low reset.
en  in  1  count enable; one step per clock while high.
up  in  1  direction: 1 = increment, 0 = decrement.
load  in  1  synchronous load strobe.
load_val  in  4*DIGITS  BCD value to load.
out  out  4*DIGITS  current count, BCD, digit 0 in [3:0].
wrap  out  1  registered one-cycle pulse on range wrap (or on a saturation hit, see Optional Feature).
load_err  out  1  registered one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-count): out=MIN_BCD, wrap=0, load_err=0 immediately; held while rst=0.
- Priority per rising edge: load > en > hold.
- Load: accepted iff every nibble of load_val ≤ 9 and MIN_BCD ≤ load_val ≤ MAX_BCD (BCD compare equals binary compare on valid BCD). Accepted: out=load_val next cycle, load_err=0. Rejected: out unchanged, load_err=1 for one cycle. en is ignored in a load cycle; wrap=0.
- Up, out≠MAX_BCD: BCD increment. Digit i increments iff all lower digits are 9; a digit at 9 that increments becomes 0.
- Up, out==MAX_BCD: out=MIN_BCD, wrap=1 in the same cycle out shows MIN_BCD.
- Down, out≠MIN_BCD: BCD decrement. Digit i decrements iff all lower digits are 0; a digit at 0 that decrements becomes 9.
- Down, out==MIN_BCD: out=MAX_BCD, wrap=1.
- en=0 and load=0: out held; wrap=0, load_err=0.
- Single-cycle latency: every change in out, wrap and load_err is visible the clock after the triggering edge inputs. No combinational input→output paths.
- out never holds a non-BCD nibble, and never leaves [MIN_BCD, MAX_BCD], after reset.
- Direction may change on any cycle. It takes effect on that edge with no dead cycle.

Optional Feature:
Macro BCD_COUNTER_SATURATE_EN.
- Defined: no wrap. Up at MAX_BCD holds MAX_BCD and down at MIN_BCD holds MIN_BCD. wrap pulses 1 for each enabled cycle that is blocked at a limit.
- Undefined: wrap-around behaviour as specified in Behaviour.

Test Plan:
1. DIGITS=2 defaults. Assert rst=0 between clock edges -> out=8'h01 immediately, wrap=0, load_err=0. Release, en=0 for 3 clocks -> out stays 8'h01.
2. en=1, up=1 from 8'h09 -> 8'h10; 8'h19 -> 8'h20; at 8'h99 -> 8'h01 with wrap=1 for exactly one cycle, then wrap=0 at 8'h02. With BCD_COUNTER_SATURATE_EN -> stays 8'h99, wrap=1 every cycle.
3. en=1, up=0 from 8'h10 -> 8'h09; at 8'h01 -> 8'h99 with wrap=1. Toggle up every cycle from 8'h50 -> 51,50,51,50.
4. Loads with en=1: load_val=8'h5A -> out unchanged, load_err=1. load_val=8'h00 (below MIN) -> rejected, load_err=1. load_val=8'h42 -> out=8'h42 next cycle, load_err=0, no increment that cycle.
5. DIGITS=3, MIN_BCD='h000, MAX_BCD='h599. Up from 12'h199 -> 12'h200; 12'h599 -> 12'h000, wrap=1. Down from 12'h300 -> 12'h299.
6. Assert rst=0 mid-count at 8'h37 while load=1 -> out=8'h01 asynchronously. Load is lost; counting resumes from 8'h02 on the first enabled edge after release.

Source files
------------

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with programmable [MIN_BCD, MAX_BCD] range, load and flags.
// Define BCD_COUNTER_SATURATE_EN to hold at the range limits instead of wrapping.
module bcd_counter_n #(
  parameter int unsigned DIGITS = 2,
  parameter logic [4*DIGITS-1:0] MIN_BCD = (4*DIGITS)'('h01),
  parameter logic [4*DIGITS-1:0] MAX_BCD = (4*DIGITS)'('h99)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   out,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

`ifdef BCD_COUNTER_SATURATE_EN
  localparam logic [W-1:0] LimitUpVal = MAX_BCD;
  localparam logic [W-1:0] LimitDnVal = MIN_BCD;
`else
  localparam logic [W-1:0] LimitUpVal = MIN_BCD;
  localparam logic [W-1:0] LimitDnVal = MAX_BCD;
`endif

  logic [W-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;
  logic [W-1:0] inc_val, dec_val;
  logic         load_bcd_ok, load_ok;

  always_comb begin
    load_bcd_ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_bcd_ok = 1'b0;
    end
  end

  // On valid BCD the binary magnitude compare matches the decimal one.
  assign load_ok = load_bcd_ok && (load_val >= MIN_BCD) && (load_val <= MAX_BCD);

  always_comb begin
    logic carry;
    logic borrow;
    inc_val = count_q;
    dec_val = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (load) begin
      if (load_ok) count_d = load_val;
      else         err_d   = 1'b1;
    end else if (en) begin
      if (up) begin
        if (count_q == MAX_BCD) begin
          count_d = LimitUpVal;
          wrap_d  = 1'b1;
        end else begin
          count_d = inc_val;
        end
      end else begin
        if (count_q == MIN_BCD) begin
          count_d = LimitDnVal;
          wrap_d  = 1'b1;
        end else begin
          count_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= MIN_BCD;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign out      = count_q;
  assign wrap     = wrap_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n: a 2-digit default instance and a 3-digit 000..599 instance
// share stimulus; an integer-arithmetic model predicts each cycle's outputs.
module tb_bcd_counter_n;

  typedef struct packed {
    logic [11:0] val;
    logic        wr;
    logic        le;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b0;
  logic [11:0] lv = '0;
  logic [7:0]  out2;
  logic        wrap2, err2;
  logic [11:0] out3;
  logic        wrap3, err3;

  int   checks = 0;
  int   errors = 0;
  int   m2 = 1;
  int   m3 = 0;
  exp_t q2[$];
  exp_t q3[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(2), .MIN_BCD(8'h01), .MAX_BCD(8'h99)) dut2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[7:0]),
    .out(out2), .wrap(wrap2), .load_err(err2)
  );

  bcd_counter_n #(.DIGITS(3), .MIN_BCD(12'h000), .MAX_BCD(12'h599)) dut3 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
    .out(out3), .wrap(wrap3), .load_err(err3)
  );

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] int2bcd(input int v, input int digits);
    logic [11:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Decimal reference: counts are plain integers, BCD only at the boundary.
  function automatic void mstep(input int cur, input bit ld, input logic [11:0] v, input bit e,
                                input bit u, input int digits, input int mn, input int mx,
                                output int nxt, output bit w, output bit er);
    bit ok;
    int val, p;
    nxt = cur;
    w   = 1'b0;
    er  = 1'b0;
    if (ld) begin
      ok  = 1'b1;
      val = 0;
      p   = 1;
      for (int i = 0; i < digits; i++) begin
        if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        val = val + int'(v[4*i +: 4]) * p;
        p   = p * 10;
      end
      if (ok && val >= mn && val <= mx) nxt = val;
      else er = 1'b1;
    end else if (e) begin
      if (u) begin
        if (cur == mx) begin
          w = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
          nxt = mx;
`else
          nxt = mn;
`endif
        end else nxt = cur + 1;
      end else begin
        if (cur == mn) begin
          w = 1'b1;
`ifdef BCD_COUNTER_SATURATE_EN
          nxt = mn;
`else
          nxt = mx;
`endif
        end else nxt = cur - 1;
      end
    end
  endfunction

  task automatic drive(input bit ld, input logic [11:0] v, input bit e, input bit u);
    int n;
    bit w, er;
    @(negedge clk);
    load = ld;
    lv   = v;
    en   = e;
    up   = u;
    mstep(m2, ld, v & 12'h0FF, e, u, 2, 1, 99, n, w, er);
    m2 = n;
    q2.push_back('{val: int2bcd(n, 2), wr: w, le: er});
    mstep(m3, ld, v, e, u, 3, 0, 599, n, w, er);
    m3 = n;
    q3.push_back('{val: int2bcd(n, 3), wr: w, le: er});
  endtask

  always @(posedge clk) begin
    #2;
    if (q2.size() > 0) begin
      mon_e = q2.pop_front();
      chk("out2", {4'h0, out2}, mon_e.val);
      chk("wrap2", {11'h0, wrap2}, {11'h0, mon_e.wr});
      chk("load_err2", {11'h0, err2}, {11'h0, mon_e.le});
    end
    if (q3.size() > 0) begin
      mon_e = q3.pop_front();
      chk("out3", out3, mon_e.val);
      chk("wrap3", {11'h0, wrap3}, {11'h0, mon_e.wr});
      chk("load_err3", {11'h0, err3}, {11'h0, mon_e.le});
    end
  end

  initial begin
    logic [11:0] v;
    // Asynchronous reset between edges, before any clock edge.
    #3 rst = 1'b0;
    #1;
    chk("rst_out2", {4'h0, out2}, 12'h001);
    chk("rst_out3", out3, 12'h000);
    chk("rst_flags", {8'h0, wrap2, err2, wrap3, err3}, 12'h000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m2 = 1;
    m3 = 0;
    repeat (3) drive(1'b0, 12'h000, 1'b0, 1'b0);

    // Up across digit boundaries and the top of range.
    drive(1'b1, 12'h009, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b1);
    drive(1'b1, 12'h019, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b1);
    drive(1'b1, 12'h099, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 12'h000, 1'b1, 1'b1);

    // Down across boundaries and the bottom of range; direction toggling.
    drive(1'b1, 12'h010, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b0);
    drive(1'b1, 12'h001, 1'b0, 1'b0);
    repeat (2) drive(1'b0, 12'h000, 1'b1, 1'b0);
    drive(1'b1, 12'h050, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 12'h000, 1'b1, (i % 2) == 0);

    // Loads with en high: non-BCD, below range, accepted.
    drive(1'b1, 12'h05A, 1'b1, 1'b1);
    drive(1'b1, 12'h000, 1'b1, 1'b1);
    drive(1'b1, 12'h042, 1'b1, 1'b1);
    drive(1'b0, 12'h000, 1'b0, 1'b1);

    // Three-digit range points.
    drive(1'b1, 12'h199, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b1);
    drive(1'b1, 12'h599, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b1);
    drive(1'b1, 12'h600, 1'b0, 1'b0);
    drive(1'b1, 12'h300, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 1'b1, 1'b0);

    // Reset mid-count while a load is pending.
    drive(1'b1, 12'h037, 1'b0, 1'b0);
    @(negedge clk);
    load = 1'b1;
    lv   = 12'h055;
    en   = 1'b1;
    up   = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("midrst_out2", {4'h0, out2}, 12'h001);
    chk("midrst_out3", out3, 12'h000);
    chk("midrst_flags", {8'h0, wrap2, err2, wrap3, err3}, 12'h000);
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    en   = 1'b0;
    m2 = 1;
    m3 = 0;
    drive(1'b0, 12'h000, 1'b1, 1'b1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) v[4*k +: 4] = 4'($urandom_range(10));
      drive($urandom_range(7) == 0, v, $urandom_range(3) != 0, $urandom_range(1) == 1);
    end

    drive(1'b0, 12'h000, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("q2_drained", 12'(q2.size()), 12'h000);
    chk("q3_drained", 12'(q3.size()), 12'h000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
